// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side write port of the UART transmit FIFO.
// The host drives wr_en/wr_data and observes FIFO status flags.
interface uart_tx_fifo_if #(
    parameter int DBIT = 8
);
    logic            wr_en;
    logic [DBIT-1:0] wr_data;
    logic            full;
    logic            empty;
    logic            overflow;

    modport master (
        output wr_en, wr_data,
        input  full, empty, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO, runtime parity/stop format.
// Define UART_TX_PARITY_EN to compile in the parity bit stage.
module uart_tx_fifo #(
    parameter int DBIT       = 8,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_tick,
    uart_tx_fifo_if.slave wr_if,
    input  logic [1:0]    parity_sel,
    input  logic          two_stop,
    output logic          busy,
    output logic          tx_done_tick,
    output logic          tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(2 * OVS);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_ONE  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_TWO  = SW'(2 * OVS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    logic [DBIT-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q;
    logic            full, empty, push, pop;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            two_q, two_d;
    logic            tx_q, tx_d;
    logic [SW-1:0]   stop_last;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
    logic            par_en_q, par_en_d;
`else
    logic            unused_parity_sel;
    assign unused_parity_sel = ^parity_sel;
`endif

    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    // A full FIFO rejects the push even if the FSM pops in the same cycle.
    assign push  = wr_if.wr_en && !full;

    assign wr_if.full     = full;
    assign wr_if.empty    = empty;
    assign wr_if.overflow = ovf_q;

    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;
    assign stop_last = two_q ? S_TWO : S_ONE;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        two_d        = two_q;
        pop          = 1'b0;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
        par_en_d     = par_en_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    b_d     = mem_q[rptr_q];
                    two_d   = two_stop;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_en_d = (parity_sel == 2'b01)
                            || (parity_sel == 2'b10);
                    par_d    = (parity_sel == 2'b10)
                            ? ~^mem_q[rptr_q]
                            : ^mem_q[rptr_q];
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_ONE) begin
                        s_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_ONE) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = par_en_q ? PARITY : STOP;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_ONE) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == stop_last) begin
                        s_d          = '0;
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level follows the state being entered, keeping tx registered.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_if.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            two_q   <= 1'b0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
`endif
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            if (wr_if.wr_en && full) ovf_q <= 1'b1;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            two_q   <= two_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
            par_en_q <= par_en_d;
`endif
        end
    end
endmodule
